// File: rtl/oled_field_scheduler.sv
// Round-robin scheduler replaying producer bursts as single-word AHB-Lite writes
// into the OLED manager block registers. Define OLED_SCHED_INIT_EN for an auto-mode write after reset.
module oled_field_scheduler #(
  parameter int          NREQ = 4,
  parameter logic [31:0] BASE = 32'h5000_0000,
  parameter int          BLKW = 5
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BLKW-1:0]   req_block,
  input  logic [NREQ*3-1:0]      req_count,
  input  logic [NREQ*4*BLKW-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic [31:0]            HADDR,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [2:0]             HSIZE,
  output logic [31:0]            HWDATA,
  input  logic                   HREADY
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ADDR, S_DATA} state_t;

`ifdef OLED_SCHED_INIT_EN
  localparam state_t RST_STATE = S_INIT;
  localparam logic   RST_INIT  = 1'b1;
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_INIT  = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [IW-1:0]         last_grant_q, owner_q;
  logic [BLKW-1:0]       blk_q;
  logic [2:0]            cnt_q;
  logic [1:0]            idx_q;
  logic [4*BLKW-1:0]     data_q;
  logic                  hold_q;
  logic                  init_q;

  logic                  grant_any, can_grant, last_slot;
  logic [IW-1:0]         grant_idx;
  logic [BLKW-1:0]       win_block;
  logic [2:0]            win_cnt_raw, win_cnt;
  logic [4*BLKW-1:0]     win_data;
  logic [BLKW-1:0]       cur_slot;

  logic [31:0]           haddr_d, hwdata_d;
  logic [1:0]            htrans_d;
  logic                  hwrite_d;
  logic [NREQ-1:0]       done_d;

  // Word address of a block register; the block index wraps inside BLKW bits.
  function automatic logic [31:0] blk_addr(input logic [BLKW-1:0] b);
    return BASE + ((32'(b) + 32'd4) << 2);
  endfunction

  assign HSIZE = 3'b010;
  assign busy  = (state_q != S_IDLE);

  // Round-robin search starting just after the previous winner.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!grant_any && req_valid[(int'(last_grant_q) + off) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IW'((int'(last_grant_q) + off) % NREQ);
      end
    end
  end

  assign can_grant   = (state_q == S_IDLE) && !hold_q && grant_any;
  assign win_block   = req_block[int'(grant_idx)*BLKW +: BLKW];
  assign win_cnt_raw = req_count[int'(grant_idx)*3 +: 3];
  assign win_cnt     = (win_cnt_raw > 3'd4) ? 3'd4 : win_cnt_raw;
  assign win_data    = req_data[int'(grant_idx)*4*BLKW +: 4*BLKW];
  assign cur_slot    = data_q[int'(idx_q)*BLKW +: BLKW];
  assign last_slot   = init_q || ((3'(idx_q) + 3'd1) >= cnt_q);

  always_comb begin
    req_ready = '0;
    if (can_grant) req_ready[grant_idx] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_ADDR;
      S_IDLE: if (can_grant && win_cnt != 3'd0) state_d = S_ADDR;
      S_ADDR: if (HREADY) state_d = S_DATA;
      S_DATA: if (HREADY) state_d = last_slot ? S_IDLE : S_ADDR;
      default: state_d = RST_STATE;
    endcase
  end

  // Next values of the registered bus outputs and done strobes.
  always_comb begin
    haddr_d  = HADDR;
    hwdata_d = HWDATA;
    htrans_d = TR_IDLE;
    hwrite_d = 1'b0;
    done_d   = '0;
    case (state_q)
      S_INIT: begin
        haddr_d  = BASE;
        htrans_d = TR_NONSEQ;
        hwrite_d = 1'b1;
      end
      S_IDLE: begin
        if (can_grant) begin
          if (win_cnt == 3'd0) begin
            done_d[grant_idx] = 1'b1;
          end else begin
            haddr_d  = blk_addr(win_block);
            htrans_d = TR_NONSEQ;
            hwrite_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          hwdata_d = init_q ? 32'd0 : 32'(cur_slot);
        end else begin
          htrans_d = TR_NONSEQ;
          hwrite_d = 1'b1;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          if (last_slot) begin
            if (!init_q) done_d[owner_q] = 1'b1;
          end else begin
            haddr_d  = blk_addr(blk_q + BLKW'(1));
            htrans_d = TR_NONSEQ;
            hwrite_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (HRESET) begin
      state_q      <= RST_STATE;
      init_q       <= RST_INIT;
      last_grant_q <= IW'(NREQ - 1);
      owner_q      <= '0;
      blk_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the burst payload is cleared too, so an abandoned burst leaves nothing behind.
      data_q       <= '0;
      hold_q       <= 1'b0;
      HADDR        <= BASE;
      HTRANS       <= TR_IDLE;
      HWRITE       <= 1'b0;
      HWDATA       <= '0;
      done         <= '0;
    end else begin
      state_q <= state_d;
      HADDR   <= haddr_d;
      HTRANS  <= htrans_d;
      HWRITE  <= hwrite_d;
      HWDATA  <= hwdata_d;
      done    <= done_d;
      hold_q  <= can_grant && (win_cnt == 3'd0);
      if (can_grant) begin
        blk_q        <= win_block;
        cnt_q        <= win_cnt;
        data_q       <= win_data;
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
        idx_q        <= '0;
      end
      if (state_q == S_DATA && HREADY) begin
        if (last_slot) begin
          init_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 2'd1;
          blk_q <= blk_q + BLKW'(1);
        end
      end
    end
  end

  a_ready_onehot: assert property (@(posedge HCLK) $onehot0(req_ready));
  a_addr_stall: assert property (@(posedge HCLK) disable iff (HRESET)
    (state_q == S_ADDR && !HREADY) |=> ($stable(HADDR) && HTRANS == TR_NONSEQ));
  a_data_stall: assert property (@(posedge HCLK) disable iff (HRESET)
    (state_q == S_DATA && !HREADY) |=> $stable(HWDATA));

endmodule

// File: tb/tb_oled_field_scheduler.sv
// Directed self-checking bench for oled_field_scheduler: bursts, round-robin,
// wrap/clip, wait states, zero-count requests and reset mid-burst.
module tb_oled_field_scheduler;

  localparam int          NREQ = 4;
  localparam int          BLKW = 5;
  localparam logic [31:0] BASE = 32'h5000_0000;

  logic                   HCLK = 1'b0;
  logic                   HRESET = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*BLKW-1:0]   req_block = '0;
  logic [NREQ*3-1:0]      req_count = '0;
  logic [NREQ*4*BLKW-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready, done;
  logic                   busy, HWRITE;
  logic [31:0]            HADDR, HWDATA;
  logic [1:0]             HTRANS;
  logic [2:0]             HSIZE;
  logic                   HREADY = 1'b1;

  int tests = 0;
  int fails = 0;

`ifdef OLED_SCHED_INIT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  always #5 HCLK = ~HCLK;

  oled_field_scheduler #(.NREQ(NREQ), .BASE(BASE), .BLKW(BLKW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_block(req_block), .req_count(req_count), .req_data(req_data),
    .req_ready(req_ready), .done(done), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp;
    @(negedge HCLK);
  endtask

  task automatic set_req(input int i, input logic [4:0] blk, input logic [2:0] cnt,
                         input logic [19:0] data);
    req_block[i*BLKW +: BLKW]   = blk;
    req_count[i*3 +: 3]         = cnt;
    req_data[i*4*BLKW +: 4*BLKW] = data;
    req_valid[i]                = 1'b1;
  endtask

  task automatic reset_dut;
    logic init_seen;
    init_seen = 1'b0;
    step;
    HRESET    = 1'b1;
    req_valid = '0;
    HREADY    = 1'b1;
    step;
    smp;
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_haddr", HADDR, BASE);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_hsize", 32'(HSIZE), 32'd2);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'(BUSY_RST));
    step;
    HRESET = 1'b0;
`ifdef OLED_SCHED_INIT_EN
    smp;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      check("init_ready", 32'(req_ready), 32'd0);
      if (HTRANS == 2'b10) begin
        check("init_addr", HADDR, BASE);
        init_seen = 1'b1;
      end else if (init_seen) begin
        check("init_wdata", HWDATA, 32'd0);
      end
      step;
      smp;
    end
    check("init_write_seen", 32'(init_seen), 32'd1);
    check("init_busy_clear", 32'(busy), 32'd0);
`endif
  endtask

  initial begin
    int ord [5];
    int g;
    logic [31:0] exp_addr [4];
    ord      = '{0, 1, 2, 3, 0};
    exp_addr = '{32'h88, 32'h8C, 32'h10, 32'h14};

    // Single burst, zero wait: block 3, count 2, data {7,12}.
    reset_dut();
    step;
    set_req(0, 5'd3, 3'd2, {5'd0, 5'd0, 5'd12, 5'd7});
    smp; check("t1_ready", 32'(req_ready), 32'h1);
    step; req_valid = '0;
    smp; check("t1_a0_trans", 32'(HTRANS), 32'h2);
         check("t1_a0_write", 32'(HWRITE), 32'h1);
         check("t1_a0_addr", HADDR, BASE + 32'h1C);
    step;
    smp; check("t1_d0_trans", 32'(HTRANS), 32'h0);
         check("t1_d0_data", HWDATA, 32'd7);
         check("t1_d0_busy", 32'(busy), 32'h1);
    step;
    smp; check("t1_a1_trans", 32'(HTRANS), 32'h2);
         check("t1_a1_addr", HADDR, BASE + 32'h20);
    step;
    smp; check("t1_d1_data", HWDATA, 32'd12);
         check("t1_d1_done", 32'(done), 32'h0);
    step;
    smp; check("t1_done", 32'(done), 32'h1);
         check("t1_idle", 32'(busy), 32'h0);
    step;
    smp; check("t1_done_pulse", 32'(done), 32'h0);

    // Round-robin from reset with all requesters valid, count 1.
    reset_dut();
    step;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i * 4), 3'd1, 20'(i + 1));
    g = 0;
    for (int c = 0; c < 20; c++) begin
      smp;
      if (!busy) check("rr_onehot", 32'($countones(req_ready)), 32'd1);
      if (req_ready != '0) begin
        check("rr_grant", 32'(req_ready), 32'd1 << ord[g]);
        if (g > 0) check("rr_done", 32'(done), 32'd1 << ord[g-1]);
        g++;
      end
      if (g == 5) break;
      step;
    end
    check("rr_grants", 32'(g), 32'd5);
    step; req_valid = '0;
    for (int c = 0; c < 4; c++) step;

    // Wrap and clip: block 30, count 7 -> 4 writes at words 34, 35, 4, 5.
    step;
    set_req(2, 5'd30, 3'd7, {5'd4, 5'd3, 5'd2, 5'd1});
    smp; check("t3_ready", 32'(req_ready), 32'h4);
    step; req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      smp; check("t3_a_trans", 32'(HTRANS), 32'h2);
           check("t3_a_addr", HADDR, BASE + exp_addr[k]);
      step;
      smp; check("t3_d_trans", 32'(HTRANS), 32'h0);
           check("t3_d_data", HWDATA, 32'(k + 1));
      step;
    end
    smp; check("t3_done", 32'(done), 32'h4);
         check("t3_no_5th", 32'(HTRANS), 32'h0);
    step;
    smp; check("t3_idle_trans", 32'(HTRANS), 32'h0);
         check("t3_idle", 32'(busy), 32'h0);

    // Wait states: 3 stall cycles in ADDR, 2 in DATA.
    step;
    set_req(3, 5'd0, 3'd1, 20'd9);
    smp; check("t4_ready", 32'(req_ready), 32'h8);
    step; req_valid = '0; HREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step;
      smp; check("t4_addr_stall_trans", 32'(HTRANS), 32'h2);
           check("t4_addr_stall_addr", HADDR, BASE + 32'h10);
    end
    step; HREADY = 1'b1;
    smp; check("t4_addr_last", HADDR, BASE + 32'h10);
    step; HREADY = 1'b0;
    smp; check("t4_data_trans", 32'(HTRANS), 32'h0);
         check("t4_data0", HWDATA, 32'd9);
    step;
    smp; check("t4_data1", HWDATA, 32'd9);
         check("t4_nodone1", 32'(done), 32'h0);
    step; HREADY = 1'b1;
    smp; check("t4_data2", HWDATA, 32'd9);
         check("t4_nodone2", 32'(done), 32'h0);
    step;
    smp; check("t4_done", 32'(done), 32'h8);

    // Count 0: no bus activity, done next cycle, no grant in the done cycle.
    step;
    set_req(1, 5'd7, 3'd0, 20'd0);
    smp; check("t5_ready", 32'(req_ready), 32'h2);
         check("t5_trans0", 32'(HTRANS), 32'h0);
    step;
    set_req(0, 5'd2, 3'd1, 20'd5);
    smp; check("t5_no_grant", 32'(req_ready), 32'h0);
         check("t5_done", 32'(done), 32'h2);
         check("t5_trans1", 32'(HTRANS), 32'h0);
         check("t5_busy", 32'(busy), 32'h0);
    step; req_valid = '0;
    smp; check("t5_done_pulse", 32'(done), 32'h0);
         check("t5_trans2", 32'(HTRANS), 32'h0);

    // Reset asserted during DATA abandons the burst.
    step;
    set_req(0, 5'd5, 3'd2, {5'd0, 5'd0, 5'd22, 5'd11});
    smp; check("t6_ready", 32'(req_ready), 32'h1);
    step; req_valid = '0;
    smp; check("t6_addr_trans", 32'(HTRANS), 32'h2);
         check("t6_addr", HADDR, BASE + 32'h24);
    step; HRESET = 1'b1;
    smp; check("t6_data", HWDATA, 32'd11);
    step; HRESET = 1'b0;
    smp; check("t6_rst_trans", 32'(HTRANS), 32'h0);
         check("t6_rst_addr", HADDR, BASE);
         check("t6_rst_done", 32'(done), 32'h0);
         check("t6_rst_busy", 32'(busy), 32'(BUSY_RST));
    for (int c = 0; c < 6; c++) begin
      step;
      smp; check("t6_no_done", 32'(done), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
